ahbl_to_apb_bridge: RTL and testbench

AHB-Lite slave to APB master bridge downstream of the Hazard5 single-port AHB-Lite master, typically behind the system interconnect's peripheral slot. Each accepted AHB-Lite transfer becomes one APB SETUP/ACCESS sequence. APB wait states are forwarded as AHB-Lite data-phase stalls. PSLVERR is converted to the AHB-Lite two-cycle ERROR response.

---
 rtl/ahbl_to_apb_bridge.sv | 144 ++++++++++++++
 tb/tb_ahbl_to_apb_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per accepted AHB-Lite transfer.
// Optional byte strobes (apbm_pstrb) are enabled with `define AHBL_APB_PSTRB_EN.
module ahbl_to_apb_bridge #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic              ahbls_hsel,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  output logic [W_ADDR-1:0] apbm_paddr,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_DATA-1:0] apbm_pwdata,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
`ifdef AHBL_APB_PSTRB_EN
  ,
  output logic [W_DATA/8-1:0] apbm_pstrb
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR
  } state_t;

  state_t state;
  state_t next_state;

  logic              accept;
  logic [W_ADDR-1:0] paddr_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;

  assign accept = ahbls_hsel && ahbls_htrans[1] && ahbls_hready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state     <= next_state;
      psel_q    <= (next_state == S_SETUP) || (next_state == S_ACCESS);
      penable_q <= (next_state == S_ACCESS);
    end
  end

  // Held until the next accept, so the APB address is stable for the whole transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      paddr_q  <= ahbls_haddr;
      pwrite_q <= ahbls_hwrite;
    end
  end

  always_comb begin
    next_state        = state;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_SETUP;
      end
      S_SETUP: begin
        ahbls_hready_resp = 1'b0;
        next_state        = S_ACCESS;
      end
      S_ACCESS: begin
        if (!apbm_pready) begin
          ahbls_hready_resp = 1'b0;
        end else if (apbm_pslverr) begin
          ahbls_hready_resp = 1'b0;
          ahbls_hresp       = 1'b1;
          next_state        = S_ERR;
        end else begin
          next_state = accept ? S_SETUP : S_IDLE;
        end
      end
      S_ERR: begin
        ahbls_hresp = 1'b1;
        next_state  = accept ? S_SETUP : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign apbm_paddr   = paddr_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_psel    = psel_q;
  assign apbm_penable = penable_q;
  assign apbm_pwdata  = ahbls_hwdata;
  assign ahbls_hrdata = apbm_prdata;

`ifdef AHBL_APB_PSTRB_EN
  logic [W_DATA/8-1:0] strb_d;
  logic [W_DATA/8-1:0] strb_q;
  logic                unused_inputs;

  // Reads carry no strobes; writes get the byte lanes selected by size and low address bits
  always_comb begin
    strb_d = '0;
    if (ahbls_hwrite) begin
      case (ahbls_hsize)
        3'b000:  strb_d = {{(W_DATA/8-1){1'b0}}, 1'b1} << ahbls_haddr[1:0];
        3'b001:  strb_d = {{(W_DATA/8-2){1'b0}}, 2'b11} << {ahbls_haddr[1], 1'b0};
        default: strb_d = '1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_q <= '0;
    end else if (accept) begin
      strb_q <= strb_d;
    end
  end

  assign apbm_pstrb    = strb_q;
  assign unused_inputs = ahbls_htrans[0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_htrans[0], ahbls_hsize};
`endif

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Directed self-checking bench for ahbl_to_apb_bridge; strobe checks run when AHBL_APB_PSTRB_EN is defined.
module tb_ahbl_to_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic        ahbls_hsel;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [31:0] apbm_paddr;
  logic        apbm_psel;
  logic        apbm_penable;
  logic        apbm_pwrite;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata;
  logic        apbm_pready;
  logic        apbm_pslverr;
`ifdef AHBL_APB_PSTRB_EN
  logic [3:0]  apbm_pstrb;
`endif

  int assertions = 0;
  int failures   = 0;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  ahbl_to_apb_bridge #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_hsel        (ahbls_hsel),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .apbm_paddr        (apbm_paddr),
    .apbm_psel         (apbm_psel),
    .apbm_penable      (apbm_penable),
    .apbm_pwrite       (apbm_pwrite),
    .apbm_pwdata       (apbm_pwdata),
    .apbm_prdata       (apbm_prdata),
    .apbm_pready       (apbm_pready),
    .apbm_pslverr      (apbm_pslverr)
`ifdef AHBL_APB_PSTRB_EN
    ,
    .apbm_pstrb        (apbm_pstrb)
`endif
  );

  always #5 clk = ~clk;

  task applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                     input logic [31:0] addr, input logic [2:0] size, input logic hready,
                     input logic [31:0] wdata, input logic pready, input logic pslverr,
                     input logic [31:0] prdata);
    ahbls_hsel   = sel;
    ahbls_htrans = trans;
    ahbls_hwrite = write;
    ahbls_haddr  = addr;
    ahbls_hsize  = size;
    ahbls_hready = hready;
    ahbls_hwdata = wdata;
    apbm_pready  = pready;
    apbm_pslverr = pslverr;
    apbm_prdata  = prdata;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task checkCtrl(input string tag, input logic psel, input logic penable,
                 input logic hready_resp, input logic hresp);
    checkOutput({tag, ".psel"}, {31'b0, apbm_psel}, {31'b0, psel});
    checkOutput({tag, ".penable"}, {31'b0, apbm_penable}, {31'b0, penable});
    checkOutput({tag, ".hready_resp"}, {31'b0, ahbls_hready_resp}, {31'b0, hready_resp});
    checkOutput({tag, ".hresp"}, {31'b0, ahbls_hresp}, {31'b0, hresp});
  endtask

  task midCycle();
    @(negedge clk);
  endtask

  task nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 0, 0, 32'h0);
    nextCycle();
    nextCycle();
    midCycle();
    checkCtrl("reset", 0, 0, 1, 0);
    checkOutput("reset.paddr", apbm_paddr, 32'h0);
    checkOutput("reset.pwrite", {31'b0, apbm_pwrite}, 32'h0);
    nextCycle();
    rst_n = 1'b1;

    // IDLE/BUSY and unselected transfers are ignored
    applyStimulus(1, 2'b01, 1, 32'h5000_0000, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    midCycle(); checkCtrl("busy_ignored", 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, NSEQ, 1, 32'h5000_0000, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    midCycle(); checkCtrl("unsel_ignored", 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    midCycle(); checkCtrl("still_idle", 0, 0, 1, 0);
    checkOutput("still_idle.paddr", apbm_paddr, 32'h0);
    nextCycle();

    // zero-wait read
    applyStimulus(1, NSEQ, 0, 32'h4000_0010, 3'd2, 1, 32'h0, 1, 0, 32'hDEAD_BEEF);
    midCycle(); checkCtrl("rd.addr", 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 1, 0, 32'hDEAD_BEEF);
    midCycle(); checkCtrl("rd.setup", 1, 0, 0, 0);
    checkOutput("rd.setup.paddr", apbm_paddr, 32'h4000_0010);
    checkOutput("rd.setup.pwrite", {31'b0, apbm_pwrite}, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'hDEAD_BEEF);
    midCycle(); checkCtrl("rd.access", 1, 1, 1, 0);
    checkOutput("rd.hrdata", ahbls_hrdata, 32'hDEAD_BEEF);
    nextCycle();
    midCycle(); checkCtrl("rd.done", 0, 0, 1, 0);
    nextCycle();

    // write with three APB wait states
    applyStimulus(1, NSEQ, 1, 32'h4000_0004, 3'd2, 1, 32'h0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h1234_5678, 0, 0, 32'h0);
    midCycle(); checkCtrl("wr.setup", 1, 0, 0, 0);
    checkOutput("wr.setup.paddr", apbm_paddr, 32'h4000_0004);
    checkOutput("wr.setup.pwrite", {31'b0, apbm_pwrite}, 32'h1);
    checkOutput("wr.setup.pwdata", apbm_pwdata, 32'h1234_5678);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      midCycle(); checkCtrl("wr.wait", 1, 1, 0, 0);
      checkOutput("wr.wait.pwdata", apbm_pwdata, 32'h1234_5678);
      nextCycle();
    end
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h1234_5678, 1, 0, 32'h0);
    midCycle(); checkCtrl("wr.access", 1, 1, 1, 0);
    checkOutput("wr.access.pwdata", apbm_pwdata, 32'h1234_5678);
    nextCycle();
    midCycle(); checkCtrl("wr.done", 0, 0, 1, 0);
    nextCycle();

    // APB error becomes a two-cycle ERROR response
    applyStimulus(1, NSEQ, 0, 32'h4000_0020, 3'd2, 1, 32'h0, 1, 1, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 1, 1, 32'h0);
    midCycle(); checkCtrl("err.setup", 1, 0, 0, 0);
    nextCycle();
    midCycle(); checkCtrl("err.cycle1", 1, 1, 0, 1);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 0, 0, 32'h0);
    midCycle(); checkCtrl("err.cycle2", 0, 0, 1, 1);
    nextCycle();
    midCycle(); checkCtrl("err.done", 0, 0, 1, 0);
    nextCycle();

    // back-to-back NSEQ then SEQ
    applyStimulus(1, NSEQ, 0, 32'h0000_0000, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    nextCycle();
    applyStimulus(1, SEQ, 0, 32'h0000_0004, 3'd2, 0, 32'h0, 1, 0, 32'hA5A5_0000);
    midCycle(); checkCtrl("b2b.setup1", 1, 0, 0, 0);
    checkOutput("b2b.setup1.paddr", apbm_paddr, 32'h0);
    nextCycle();
    applyStimulus(1, SEQ, 0, 32'h0000_0004, 3'd2, 1, 32'h0, 1, 0, 32'hA5A5_0000);
    midCycle(); checkCtrl("b2b.access1", 1, 1, 1, 0);
    checkOutput("b2b.hrdata1", ahbls_hrdata, 32'hA5A5_0000);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 1, 0, 32'h1111_2222);
    midCycle(); checkCtrl("b2b.setup2", 1, 0, 0, 0);
    checkOutput("b2b.setup2.paddr", apbm_paddr, 32'h4);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'h1111_2222);
    midCycle(); checkCtrl("b2b.access2", 1, 1, 1, 0);
    checkOutput("b2b.hrdata2", ahbls_hrdata, 32'h1111_2222);
    nextCycle();
    midCycle(); checkCtrl("b2b.done", 0, 0, 1, 0);
    nextCycle();

    // reset in the middle of a stalled ACCESS
    applyStimulus(1, NSEQ, 0, 32'h4000_0030, 3'd2, 1, 32'h0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 0, 0, 32'h0);
    nextCycle();
    rst_n = 1'b0;
    midCycle(); checkCtrl("rstmid.access", 1, 1, 0, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 0, 0, 32'h0);
    midCycle(); checkCtrl("rstmid.after", 0, 0, 1, 0);
    checkOutput("rstmid.paddr", apbm_paddr, 32'h0);
    nextCycle();
    applyStimulus(1, NSEQ, 0, 32'h4000_0040, 3'd2, 1, 32'h0, 1, 0, 32'hCAFE_F00D);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 1, 0, 32'hCAFE_F00D);
    midCycle(); checkCtrl("rstmid.rd.setup", 1, 0, 0, 0);
    checkOutput("rstmid.rd.paddr", apbm_paddr, 32'h4000_0040);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'hCAFE_F00D);
    midCycle(); checkCtrl("rstmid.rd.access", 1, 1, 1, 0);
    checkOutput("rstmid.rd.hrdata", ahbls_hrdata, 32'hCAFE_F00D);
    nextCycle();

`ifdef AHBL_APB_PSTRB_EN
    // strobes: byte at offset 3, halfword at offset 2, then a read
    applyStimulus(1, NSEQ, 1, 32'h4000_0003, 3'd0, 1, 32'h0, 1, 0, 32'h0);
    nextCycle();
    applyStimulus(1, NSEQ, 1, 32'h4000_0042, 3'd1, 0, 32'h0, 1, 0, 32'h0);
    midCycle(); checkOutput("pstrb.byte", {28'b0, apbm_pstrb}, 32'h8);
    nextCycle();
    applyStimulus(1, NSEQ, 1, 32'h4000_0042, 3'd1, 1, 32'h0, 1, 0, 32'h0);
    nextCycle();
    applyStimulus(1, NSEQ, 0, 32'h4000_0050, 3'd2, 0, 32'h0, 1, 0, 32'h0);
    midCycle(); checkOutput("pstrb.half", {28'b0, apbm_pstrb}, 32'hC);
    nextCycle();
    applyStimulus(1, NSEQ, 0, 32'h4000_0050, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 0, 32'h0, 1, 0, 32'h0);
    midCycle(); checkOutput("pstrb.read", {28'b0, apbm_pstrb}, 32'h0);
    nextCycle();
    applyStimulus(0, IDLE, 0, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'h0);
    nextCycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
